// File: rtl/ecc_sed_checker_pkg.sv
// ----------------------------------------------------------------------------
// ecc_sed_pkg
// Shared definitions for the single-error-detect checker and its bench models.
//   SED_DATA_W  : default payload width
//   SED_CW_W    : default codeword width (payload + parity)
//   SED_MAX_W   : widest codeword sed_parity() accepts (zero-extended)
//   ecc_alarm_state_t : consecutive-error alarm FSM states
//   sed_parity(): XOR reduction of a codeword; 1 means parity error
// ----------------------------------------------------------------------------
package ecc_sed_pkg;

    localparam int SED_DATA_W = 12;
    localparam int SED_CW_W   = SED_DATA_W + 1;
    localparam int SED_MAX_W  = 64;

    typedef enum logic {
        ST_OK    = 1'b0,
        ST_ALARM = 1'b1
    } ecc_alarm_state_t;

    // Zero extension does not change an XOR reduction, so callers of any
    // codeword width up to SED_MAX_W can share this one function.
    function automatic logic sed_parity(input logic [SED_MAX_W-1:0] cw);
        return ^cw;
    endfunction

endpackage

// File: rtl/ecc_sed_checker_if.sv
// ----------------------------------------------------------------------------
// ecc_sed_checker_if
// Bus between the encoder, the checker, downstream and the health monitor.
//   enc_valid/enc_ready/enc_codeword : codeword input handshake
//   dec_valid/dec_ready/dec_data/dec_error : payload output handshake
//   err_sticky/err_count/alarm/err_clear   : error statistics
// Modports: master = environment side, slave = checker side.
// ----------------------------------------------------------------------------
interface ecc_sed_checker_if #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 16
);
    logic              enc_valid;
    logic              enc_ready;
    logic [DATA_W:0]   enc_codeword;
    logic              dec_valid;
    logic              dec_ready;
    logic [DATA_W-1:0] dec_data;
    logic              dec_error;
    logic              err_sticky;
    logic [CNT_W-1:0]  err_count;
    logic              alarm;
    logic              err_clear;

    modport master (
        output enc_valid, enc_codeword, dec_ready, err_clear,
        input  enc_ready, dec_valid, dec_data, dec_error,
               err_sticky, err_count, alarm
    );

    modport slave (
        input  enc_valid, enc_codeword, dec_ready, err_clear,
        output enc_ready, dec_valid, dec_data, dec_error,
               err_sticky, err_count, alarm
    );
endinterface

// File: rtl/ecc_sed_checker_err_stats.sv
// ----------------------------------------------------------------------------
// ecc_sed_err_stats
// Error statistics for accepted codewords: saturating error counter, sticky
// flag, saturating consecutive-error counter and the OK/ALARM FSM.
//   clk, rst       : clock, synchronous active-high reset
//   i_accept       : a codeword is accepted this cycle
//   i_perr         : parity error of that codeword
//   i_clear        : clear statistics (applied before the same-cycle word)
//   o_err_sticky   : any error seen since reset/clear
//   o_err_count    : accepted erroneous words, saturating
//   o_alarm        : FSM is in ALARM
// ----------------------------------------------------------------------------
module ecc_sed_err_stats
    import ecc_sed_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int ALARM_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_accept,
    input  logic             i_perr,
    input  logic             i_clear,
    output logic             o_err_sticky,
    output logic [CNT_W-1:0] o_err_count,
    output logic             o_alarm
);

    localparam logic [7:0] THRESH = 8'(ALARM_THRESH);

    logic [CNT_W-1:0] r_count;
    logic             r_sticky;
    logic [7:0]       r_consec;
    ecc_alarm_state_t r_state;

    logic [CNT_W-1:0] w_count_base, w_count_nxt;
    logic             w_sticky_base, w_sticky_nxt;
    logic [7:0]       w_consec_base, w_consec_nxt;
    logic             w_err_word;
    logic             w_hit_thresh;
    ecc_alarm_state_t w_state_nxt;

    // Clear acts first, then the word accepted in the same cycle is counted
    // on top of the cleared values.
    always_comb begin
        w_count_base  = i_clear ? '0    : r_count;
        w_sticky_base = i_clear ? 1'b0  : r_sticky;
        w_consec_base = i_clear ? 8'd0  : r_consec;
        w_err_word    = i_accept && i_perr;

        w_count_nxt   = w_count_base;
        w_sticky_nxt  = w_sticky_base;
        w_consec_nxt  = w_consec_base;

        if (w_err_word) begin
            if (w_count_base != '1)
                w_count_nxt = w_count_base + CNT_W'(1);
            w_sticky_nxt = 1'b1;
            if (w_consec_base < THRESH)
                w_consec_nxt = w_consec_base + 8'd1;
        end else if (i_accept) begin
            w_consec_nxt = 8'd0;
        end

        w_hit_thresh = w_err_word && (w_consec_nxt == THRESH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_sticky <= 1'b0;
            r_consec <= 8'd0;
        end else begin
            r_count  <= w_count_nxt;
            r_sticky <= w_sticky_nxt;
            r_consec <= w_consec_nxt;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_OK;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state / output. ALARM is left only through clear; a clean
    // word merely zeroes consec.
    always_comb begin
        w_state_nxt = r_state;
        o_alarm     = 1'b0;
        case (r_state)
            ST_OK: begin
                if (w_hit_thresh)
                    w_state_nxt = ST_ALARM;
            end
            ST_ALARM: begin
                o_alarm = 1'b1;
                if (i_clear)
                    w_state_nxt = w_hit_thresh ? ST_ALARM : ST_OK;
            end
            default: w_state_nxt = ST_OK;
        endcase
    end

    assign o_err_sticky = r_sticky;
    assign o_err_count  = r_count;

endmodule

// File: rtl/ecc_sed_checker.sv
// ----------------------------------------------------------------------------
// ecc_sed_checker
// Checks even parity over a {parity, data} codeword, strips the parity bit
// and forwards the payload through a one-entry registered output stage with
// valid/ready backpressure. Error statistics live in ecc_sed_err_stats.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (discards a held word)
//   bus  : ecc_sed_checker_if.slave (enc_* input, dec_* output, statistics)
// Optional build macro ECC_SED_ERR_DROP_EN: erroneous words are consumed and
// counted but never presented; dec_error is tied low.
// ----------------------------------------------------------------------------
module ecc_sed_checker
    import ecc_sed_pkg::*;
#(
    parameter int DATA_W       = SED_DATA_W,
    parameter int CNT_W        = 16,
    parameter int ALARM_THRESH = 4
) (
    input  logic               clk,
    input  logic               rst,
    ecc_sed_checker_if.slave   bus
);

    logic              r_dec_valid;
    logic [DATA_W-1:0] r_dec_data;
    logic              w_enc_ready;
    logic              w_accept;
    logic              w_perr;
    logic              w_err_sticky;
    logic [CNT_W-1:0]  w_err_count;
    logic              w_alarm;

    // Accept whenever the stage is empty or draining this cycle, so a drain
    // and a new word overlap with no bubble.
    assign w_enc_ready = !r_dec_valid || bus.dec_ready;
    assign w_accept    = bus.enc_valid && w_enc_ready;
    assign w_perr      = sed_parity(SED_MAX_W'(bus.enc_codeword));

`ifdef ECC_SED_ERR_DROP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_valid <= 1'b0;
            r_dec_data  <= '0;
        end else if (w_accept) begin
            // A bad word still frees the stage; it just never shows up.
            r_dec_valid <= !w_perr;
            r_dec_data  <= bus.enc_codeword[DATA_W-1:0];
        end else if (bus.dec_ready) begin
            r_dec_valid <= 1'b0;
        end
    end

    assign bus.dec_error = 1'b0;
`else
    logic r_dec_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_valid <= 1'b0;
            r_dec_data  <= '0;
            r_dec_error <= 1'b0;
        end else if (w_accept) begin
            r_dec_valid <= 1'b1;
            r_dec_data  <= bus.enc_codeword[DATA_W-1:0];
            r_dec_error <= w_perr;
        end else if (bus.dec_ready) begin
            r_dec_valid <= 1'b0;
        end
    end

    assign bus.dec_error = r_dec_error;
`endif

    ecc_sed_err_stats #(
        .CNT_W        (CNT_W),
        .ALARM_THRESH (ALARM_THRESH)
    ) u_stats (
        .clk          (clk),
        .rst          (rst),
        .i_accept     (w_accept),
        .i_perr       (w_perr),
        .i_clear      (bus.err_clear),
        .o_err_sticky (w_err_sticky),
        .o_err_count  (w_err_count),
        .o_alarm      (w_alarm)
    );

    assign bus.enc_ready  = w_enc_ready;
    assign bus.dec_valid  = r_dec_valid;
    assign bus.dec_data   = r_dec_data;
    assign bus.err_sticky = w_err_sticky;
    assign bus.err_count  = w_err_count;
    assign bus.alarm      = w_alarm;

endmodule

// File: tb/tb_ecc_sed_checker.sv
// ----------------------------------------------------------------------------
// tb_ecc_sed_checker
// Two checkers (16-bit and 2-bit error counters) share one stimulus stream.
// A behavioural model tracks the expected state; directed phases pin the
// model with literal values, then a random phase runs against the model.
// ----------------------------------------------------------------------------
module tb_ecc_sed_checker;

    localparam int DW  = 12;
    localparam int CWA = 16;
    localparam int CWB = 2;
    localparam int TH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ecc_sed_checker_if #(.DATA_W(DW), .CNT_W(CWA)) ifa ();
    ecc_sed_checker_if #(.DATA_W(DW), .CNT_W(CWB)) ifb ();

    ecc_sed_checker #(.DATA_W(DW), .CNT_W(CWA), .ALARM_THRESH(TH)) u_dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave));
    ecc_sed_checker #(.DATA_W(DW), .CNT_W(CWB), .ALARM_THRESH(TH)) u_dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave));

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        m_valid  = 0;
    bit [11:0] m_data   = 0;
    bit        m_err    = 0;
    bit        m_sticky = 0;
    int        m_cnt_a  = 0;
    int        m_cnt_b  = 0;
    int        m_consec = 0;
    bit        m_alarm  = 0;

    always @(posedge clk) begin
        bit acc, perr;
        acc  = ifa.enc_valid && (!m_valid || ifa.dec_ready);
        perr = ($countones(ifa.enc_codeword) % 2) == 1;
        if (rst) begin
            m_valid = 0; m_data = 0; m_err = 0; m_sticky = 0;
            m_cnt_a = 0; m_cnt_b = 0; m_consec = 0; m_alarm = 0;
        end else begin
            if (ifa.err_clear) begin
                m_cnt_a = 0; m_cnt_b = 0; m_sticky = 0; m_consec = 0; m_alarm = 0;
            end
            if (acc && perr) begin
                m_cnt_a  = (m_cnt_a < (1 << CWA) - 1) ? m_cnt_a + 1 : m_cnt_a;
                m_cnt_b  = (m_cnt_b < (1 << CWB) - 1) ? m_cnt_b + 1 : m_cnt_b;
                m_sticky = 1;
                m_consec = (m_consec < TH) ? m_consec + 1 : TH;
                if (m_consec == TH) m_alarm = 1;
            end else if (acc) begin
                m_consec = 0;
            end
            if (acc) begin
`ifdef ECC_SED_ERR_DROP_EN
                m_valid = !perr;
                m_err   = 0;
`else
                m_valid = 1;
                m_err   = perr;
`endif
                m_data  = ifa.enc_codeword[11:0];
            end else if (ifa.dec_ready) begin
                m_valid = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("enc_ready", 32'(ifa.enc_ready), 32'(!m_valid || ifa.dec_ready));
            chk("dec_valid", 32'(ifa.dec_valid), 32'(m_valid));
            chk("dec_valid_b", 32'(ifb.dec_valid), 32'(m_valid));
            if (m_valid) begin
                chk("dec_data", 32'(ifa.dec_data), 32'(m_data));
                chk("dec_error", 32'(ifa.dec_error), 32'(m_err));
            end
            chk("err_sticky", 32'(ifa.err_sticky), 32'(m_sticky));
            chk("err_count_a", 32'(ifa.err_count), 32'(m_cnt_a));
            chk("err_count_b", 32'(ifb.err_count), 32'(m_cnt_b));
            chk("alarm", 32'(ifa.alarm), 32'(m_alarm));
            chk("alarm_b", 32'(ifb.alarm), 32'(m_alarm));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input bit v, input logic [12:0] cw, input bit rdy, input bit clr);
        ifa.enc_valid = v;  ifa.enc_codeword = cw;  ifa.dec_ready = rdy;  ifa.err_clear = clr;
        ifb.enc_valid = v;  ifb.enc_codeword = cw;  ifb.dec_ready = rdy;  ifb.err_clear = clr;
    endtask

    task automatic apply(input bit v, input logic [12:0] cw, input bit rdy, input bit clr);
        set_in(v, cw, rdy, clr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_in(0, 13'h0, 1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        chk("rst_valid", 32'(ifa.dec_valid), 0);
        chk("rst_data", 32'(ifa.dec_data), 0);
        chk("rst_count", 32'(ifa.err_count), 0);
        chk("rst_alarm", 32'(ifa.alarm), 0);
        rst = 1'b0;

        // clean stream
        apply(1, 13'h0A5C, 1, 0);
        chk("clean1_valid", 32'(ifa.dec_valid), 1);
        chk("clean1_data", 32'(ifa.dec_data), 32'h A5C);
        chk("clean1_err", 32'(ifa.dec_error), 0);
        apply(1, 13'h1001, 1, 0);
        chk("clean2_data", 32'(ifa.dec_data), 32'h001);
        chk("clean2_err", 32'(ifa.dec_error), 0);
        chk("clean2_count", 32'(ifa.err_count), 0);

        // single flip
        apply(1, 13'h1A5C, 1, 0);
`ifndef ECC_SED_ERR_DROP_EN
        chk("flip_data", 32'(ifa.dec_data), 32'h A5C);
        chk("flip_err", 32'(ifa.dec_error), 1);
`else
        chk("drop_valid", 32'(ifa.dec_valid), 0);
`endif
        chk("flip_count", 32'(ifa.err_count), 1);
        chk("flip_sticky", 32'(ifa.err_sticky), 1);
        chk("flip_alarm", 32'(ifa.alarm), 0);

        // backpressure
        apply(1, 13'h0A5C, 0, 0);
        chk("bp_valid", 32'(ifa.dec_valid), 1);
        for (int i = 0; i < 3; i++) begin
            apply(1, 13'h0123, 0, 0);
            chk("bp_ready", 32'(ifa.enc_ready), 0);
            chk("bp_data", 32'(ifa.dec_data), 32'h A5C);
            chk("bp_count", 32'(ifa.err_count), 1);
        end
        apply(1, 13'h0123, 1, 0);
        chk("bp_next_data", 32'(ifa.dec_data), 32'h123);
        apply(0, 13'h0, 1, 0);
        chk("bp_drain", 32'(ifa.dec_valid), 0);

        // alarm
        for (int i = 0; i < 4; i++) begin
            apply(1, 13'h1A5C, 1, 0);
            chk("alarm_ramp", 32'(ifa.alarm), (i == 3) ? 1 : 0);
        end
        chk("alarm_cnt_a", 32'(ifa.err_count), 5);
        chk("alarm_cnt_b", 32'(ifb.err_count), 3);
        apply(1, 13'h0A5C, 1, 0);
        chk("alarm_hold", 32'(ifa.alarm), 1);
        apply(0, 13'h0, 1, 1);
        chk("clr_alarm", 32'(ifa.alarm), 0);
        chk("clr_count", 32'(ifa.err_count), 0);
        chk("clr_sticky", 32'(ifa.err_sticky), 0);

        // saturation and clear race
        for (int i = 0; i < 5; i++) apply(1, 13'h1A5C, 1, 0);
        chk("sat_cnt_b", 32'(ifb.err_count), 3);
        apply(1, 13'h1A5C, 1, 0);
        chk("sat_hold_b", 32'(ifb.err_count), 3);
        apply(1, 13'h1A5C, 1, 1);
        chk("race_cnt_a", 32'(ifa.err_count), 1);
        chk("race_cnt_b", 32'(ifb.err_count), 1);
        chk("race_sticky", 32'(ifa.err_sticky), 1);
        chk("race_alarm", 32'(ifa.alarm), 0);

        // reset mid-hold
        apply(1, 13'h0A5C, 0, 0);
        chk("hold_valid", 32'(ifa.dec_valid), 1);
        rst = 1'b1;
        apply(0, 13'h0, 0, 0);
        rst = 1'b0;
        chk("mrst_valid", 32'(ifa.dec_valid), 0);
        chk("mrst_data", 32'(ifa.dec_data), 0);
        chk("mrst_err", 32'(ifa.dec_error), 0);
        chk("mrst_count", 32'(ifa.err_count), 0);
        chk("mrst_sticky", 32'(ifa.err_sticky), 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] d;
            bit bad;
            d   = 12'($urandom);
            bad = ($urandom_range(0, 99) < 55);
            rst = ($urandom_range(0, 199) == 0);
            apply($urandom_range(0, 3) != 0,
                  {(^d) ^ bad, d},
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 29) == 0);
        end
        rst = 1'b0;
        apply(0, 13'h0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
